// File: rtl/serial_add_pkg.sv
// Shared state encoding and default operand width for the bit-serial adder.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Gate-level 1-bit full adder; purely combinational, no handshake.
module fa_cell (
  output wire logic S,
  output wire logic Cout,
  input  logic      A,
  input  logic      B,
  input  logic      Cin
);

  wire logic p;
  wire logic g;
  wire logic t;

  xor x_prop (p, A, B);
  xor x_sum  (S, p, Cin);
  and a_gen  (g, A, B);
  and a_prop (t, p, Cin);
  or  o_cout (Cout, g, t);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/sub controller; done arrives WIDTH+1 cycles after an accepted start.
// Starts seen while busy or finishing are dropped, so there is no queueing.
module serial_add_ctrl #(
  parameter int WIDTH = serial_add_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import serial_add_pkg::*;

  localparam int CNTW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic             carry_msb;
  logic [CNTW-1:0]  cnt;
  logic             s_bit;
  logic             c_bit;

  fa_cell u_fa (
    .S    (s_bit),
    .Cout (c_bit),
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, so the inversion and forced carry happen at load.
            a_sr  <= a_in;
            b_sr  <= op_sub ? ~b_in : b_in;
            carry <= op_sub | cin_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          carry  <= c_bit;
          cnt    <= cnt + CNTW'(1);
          if (cnt == CNTW'(WIDTH - 1)) begin
            carry_msb <= carry;
            state     <= ST_FIN;
          end
        end
        ST_FIN: begin
          sum   <= sum_sr;
          cout  <= carry;
          ovf   <= carry_msb ^ carry;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver pushes expected results, monitor pops on done.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a_in   (a_in),
    .b_in   (b_in),
    .cin_in (cin_in),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input int a, input int b, input bit sub, input bit cin);
    exp_t e;
    int bx, c, u, sa, sbx, s;
    bx  = sub ? (255 - b) : b;
    c   = sub ? 1 : int'(cin);
    u   = a + bx + c;
    sa  = (a  >= 128) ? a  - 256 : a;
    sbx = (bx >= 128) ? bx - 256 : bx;
    s   = sa + sbx + c;
    e.sum  = W'(u % 256);
    e.cout = (u >= 256);
    e.ovf  = (s > 127) || (s < -128);
    e.cyc  = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", int'(sum), int'(e.sum));
        chk("cout", int'(cout), int'(e.cout));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // mode 0: plain op; 1: extra start at cycle 3; 2: reset at cycle 4
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                        input bit cin, input int mode, input bit use_k,
                        input logic [W-1:0] k_sum, input bit k_cout, input bit k_ovf);
    exp_t e;
    bit   busy_ok = 1'b1;
    wait_idle();
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; op_sub = sub; cin_in = cin;
    @(posedge clk);
    #1;
    e = model(int'(a), int'(b), sub, cin);
    if (use_k) begin
      e.sum = k_sum; e.cout = k_cout; e.ovf = k_ovf;
    end
    e.cyc = cyc + 9;
    if (mode != 2) sb.push_back(e);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (i == 0) begin
        start = 1'b0; a_in = $urandom; b_in = $urandom; op_sub = $urandom; cin_in = $urandom;
      end
      if (mode == 1 && i == 2) begin
        start = 1'b1; a_in = ~a; b_in = W'(b + 1); op_sub = ~sub;
      end
      if (mode == 1 && i == 3) start = 1'b0;
      if (mode == 2 && i == 3) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_cout", int'(cout), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    chk("busy_span", int'(busy_ok), 1);
  endtask

  initial begin
    int c0;
    exp_t e1, e2;

    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sum", int'(sum), 0);
    chk("reset_cout", int'(cout), 0);
    chk("reset_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h35, 8'h4A, 1'b0, 1'b0, 0, 1'b1, 8'h7F, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b1, 0, 1'b1, 8'h01, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b1, 8'h80, 1'b0, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 0, 1'b1, 8'h00, 1'b1, 1'b1);
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(8'h07, 8'h05, 1'b1, 1'b0, 0, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1, 1'b1, 8'h46, 1'b0, 1'b0);
    run_op(8'h99, 8'h11, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op(8'h40, 8'h40, 1'b0, 1'b0, 0, 1'b1, 8'h80, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Start held high: the second op must be accepted WIDTH+2 cycles after the first.
    wait_idle();
    @(negedge clk);
    start = 1'b1; a_in = 8'hC3; b_in = 8'h5A; op_sub = 1'b1; cin_in = 1'b0;
    @(posedge clk);
    #1;
    c0 = cyc;
    e1 = model(32'hC3, 32'h5A, 1'b1, 1'b0);
    e1.cyc = c0 + 9;
    sb.push_back(e1);
    repeat (10) @(negedge clk);
    a_in = 8'h6E; b_in = 8'h2D; op_sub = 1'b0; cin_in = 1'b1;
    e2 = model(32'h6E, 32'h2D, 1'b0, 1'b1);
    e2.cyc = c0 + 19;
    sb.push_back(e2);
    @(negedge clk);
    start = 1'b0;

    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
